// File: rtl/capture_pkg.sv
// capture_pkg: shared types and constants for the capture pulse-train generator.
package capture_pkg;

    // Controller states of the pulse-train sequencer
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Largest supported number of idle cycles between pulses
    localparam int GAP_MAX = 15;

    // Width of the inter-pulse gap down-counter (holds 0..GAP_MAX)
    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/capture_gen_gap_timer.sv
// gap_timer: loadable down-counter that times the idle gap between capture pulses.
// A load sets the count; expire is high in the last cycle of the gap.
module gap_timer
    import capture_pkg::*;
(
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [GAP_CNT_W-1:0] load_val,
    output logic                 expire
);

    logic [GAP_CNT_W-1:0] cnt;

    // Load the gap length, otherwise count down to zero and stop there
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - GAP_CNT_W'(1);
        end
    end

    // The first gap cycle sees cnt == GAP, so cnt == 1 marks the final one
    assign expire = (cnt == GAP_CNT_W'(1));

endmodule

// File: rtl/capture_gen.sv
// capture_gen: emits a train of single-cycle capture pulses separated by GAP idle
// cycles, followed by a one-cycle done pulse. All outputs are registered.
// Optional feature: define CAPTURE_GEN_ABORT_EN to add the abort input, which
// cuts a running train short and jumps to the done cycle.
module capture_gen
    import capture_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int GAP   = 1
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] count,
`ifdef CAPTURE_GEN_ABORT_EN
    input  logic             abort,
`endif
    output logic             ready,
    output logic             capture,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remaining
);

    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP);

    if (GAP < 0 || GAP > GAP_MAX) begin : g_gap_range
        $error("capture_gen: GAP must be within 0..15");
    end

    state_t state;
    logic   abort_hit;
    logic   last_pulse;
    logic   gap_load;
    logic   gap_expire;

`ifdef CAPTURE_GEN_ABORT_EN
    // Abort only matters while a train is running
    assign abort_hit = abort && ((state == ST_PULSE) || (state == ST_GAP));
`else
    assign abort_hit = 1'b0;
`endif

    // The pulse being emitted now is the final one of the train
    assign last_pulse = (remaining == WIDTH'(1));

    // Arm the gap timer as a non-final pulse hands over to the gap state
    assign gap_load = (state == ST_PULSE) && !last_pulse && !abort_hit && (GAP != 0);

    gap_timer u_gap_timer (
        .clock    (clock),
        .rst_n    (rst_n),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .expire   (gap_expire)
    );

    // Sequencer: state and every output are registered together
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ready     <= 1'b0;
            capture   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            capture <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    if (ready && start) begin
                        remaining <= count;
                        ready     <= 1'b0;
                        if (count != '0) begin
                            state   <= ST_PULSE;
                            capture <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_PULSE: begin
                    if (remaining != '0) begin
                        remaining <= remaining - WIDTH'(1);
                    end
                    if (abort_hit) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        remaining <= '0;
                    end else if (last_pulse) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (GAP != 0) begin
                        state <= ST_GAP;
                        busy  <= 1'b1;
                    end else begin
                        state   <= ST_PULSE;
                        capture <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (abort_hit) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        remaining <= '0;
                    end else if (gap_expire) begin
                        state   <= ST_PULSE;
                        capture <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
